// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle control FSM for the ARMv4-subset core.
// Sequences fetch/decode/execute/memory/writeback over a shared memory,
// holds the NZCV register, evaluates the condition field and stalls on
// the memory ready handshake.
// Optional build macro ARM_MC_PERF_EN adds cyc_cnt/ins_cnt counters.
module arm_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:12]     Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic             RegWrite,
  output logic [3:0]       Flags
`ifdef ARM_MC_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ins_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;

  state_t state_reg, state_next;
  // run_reg is low from reset until the first clock after release; it keeps
  // the FETCH strobes quiet and the FSM parked until then.
  logic   run_reg;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit;
  logic       cond_ex;
  logic       dp_ok, dp_nowrite, dp_cv;
  logic [1:0] dp_alu;
  logic       unused_rn;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign i_bit = Instr[25];
  assign cmd   = Instr[24:21];
  assign s_bit = Instr[20];     // S for data processing, L for memory ops
  assign rd    = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  // Condition check against the architectural flags; 1111 never executes.
  always_comb begin
    case (cond)
      4'h0:    cond_ex = Flags[2];
      4'h1:    cond_ex = ~Flags[2];
      4'h2:    cond_ex = Flags[1];
      4'h3:    cond_ex = ~Flags[1];
      4'h4:    cond_ex = Flags[3];
      4'h5:    cond_ex = ~Flags[3];
      4'h6:    cond_ex = Flags[0];
      4'h7:    cond_ex = ~Flags[0];
      4'h8:    cond_ex = Flags[1] & ~Flags[2];
      4'h9:    cond_ex = ~Flags[1] | Flags[2];
      4'hA:    cond_ex = (Flags[3] == Flags[0]);
      4'hB:    cond_ex = (Flags[3] != Flags[0]);
      4'hC:    cond_ex = ~Flags[2] & (Flags[3] == Flags[0]);
      4'hD:    cond_ex = Flags[2] | (Flags[3] != Flags[0]);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing decode: ALU op, whether Rd is written, whether C/V load.
  always_comb begin
    dp_ok      = 1'b1;
    dp_nowrite = 1'b0;
    dp_cv      = 1'b0;
    dp_alu     = 2'b00;
    case (cmd)
      4'b0100: begin dp_alu = 2'b00; dp_cv = 1'b1; end                    // ADD
      4'b0010: begin dp_alu = 2'b01; dp_cv = 1'b1; end                    // SUB
      4'b0000: dp_alu = 2'b10;                                            // AND
      4'b1100: dp_alu = 2'b11;                                            // ORR
      4'b1000: begin dp_alu = 2'b10; dp_nowrite = 1'b1; end               // TST
      4'b1010: begin dp_alu = 2'b01; dp_nowrite = 1'b1; dp_cv = 1'b1; end // CMP
      default: dp_ok = 1'b0;
    endcase
  end

  // Next-state logic; the FSM only advances once run_reg is set.
  always_comb begin
    state_next = state_reg;
    if (run_reg) begin
      case (state_reg)
        S_FETCH:  if (mem_ready) state_next = S_DECODE;
        S_DECODE: begin
          if (!cond_ex)
            state_next = S_FETCH;
          else begin
            case (op)
              2'b00:   state_next = dp_ok ? (i_bit ? S_EXECI : S_EXECR) : S_FETCH;
              2'b01:   state_next = S_MEMADR;
              2'b10:   state_next = S_BRANCH;
              default: state_next = S_FETCH;
            endcase
          end
        end
        S_EXECR, S_EXECI: state_next = S_ALUWB;
        S_MEMADR: state_next = s_bit ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
        S_MEMWR:  if (mem_ready) state_next = S_FETCH;
        default:  state_next = S_FETCH;   // ALUWB, MEMWB, BRANCH
      endcase
    end
  end

  // State, run flag and NZCV register; flags load leaving EXECR/EXECI with S set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
      run_reg   <= 1'b0;
      Flags     <= 4'b0000;
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;
      if (run_reg && (state_reg == S_EXECR || state_reg == S_EXECI) && s_bit) begin
        Flags[3:2] <= ALUFlags[3:2];
        if (dp_cv) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    RegWrite   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = run_reg & mem_ready;
        PCWrite   = run_reg & mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = {op == 2'b01, op == 2'b10};
      end
      S_EXECR: ALUControl = dp_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      S_ALUWB: begin
        RegWrite = ~dp_nowrite;
        PCWrite  = ~dp_nowrite & (rd == 4'hF);
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCWrite   = (rd == 4'hF);
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARM_MC_PERF_EN
  // Cycle count and retirement count (every return to FETCH).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (state_reg != S_FETCH && state_next == S_FETCH)
        ins_cnt <= ins_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// Testbench for arm_mc_controller: directed spec scenarios plus randomized
// instruction streams checked against an instruction-level model.
module tb_arm_mc_controller;

  logic        clk;
  logic        reset_n;
  logic [31:12] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0]  result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0]  flags;
`ifdef ARM_MC_PERF_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] flags_m;   // model of the architectural NZCV register

  typedef struct {
    int         cycles;
    int         irw;
    int         rw;
    int         mw;
    int         pcw;
    int         adr;
    int         brimm;
    logic [1:0] rwsrc;
    bit         timeout;
  } meas_t;

  arm_mc_controller #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Instr      (instr),
    .ALUFlags   (alu_flags),
    .mem_ready  (mem_ready),
    .PCWrite    (pc_write),
    .AdrSrc     (adr_src),
    .MemWrite   (mem_write),
    .IRWrite    (ir_write),
    .ResultSrc  (result_src),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ALUControl (alu_control),
    .ImmSrc     (imm_src),
    .RegSrc     (reg_src),
    .RegWrite   (reg_write),
    .Flags      (flags)
`ifdef ARM_MC_PERF_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ins_cnt    (ins_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ARM condition rule: base test per pair, odd codes invert; 1111 -> never.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit r;
    case (c[3:1])
      3'd0: r = f[2];
      3'd1: r = f[1];
      3'd2: r = f[3];
      3'd3: r = f[0];
      3'd4: r = f[1] && !f[2];
      3'd5: r = (f[3] == f[0]);
      3'd6: r = !f[2] && (f[3] == f[0]);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    return r;
  endfunction

  // Instruction-level expectations: cycle count, strobe pulse counts, flags.
  task automatic model_step(input logic [31:0] ins, input logic [3:0] af,
                            input int fw, input int mw, output meas_t e);
    logic [3:0] c, cmd, rd;
    logic [1:0] op;
    bit s, impl, wr, arith;
    c = ins[31:28]; op = ins[27:26]; cmd = ins[24:21]; s = ins[20]; rd = ins[15:12];
    impl  = (cmd == 4'h4) || (cmd == 4'h2) || (cmd == 4'h0) || (cmd == 4'hC) ||
            (cmd == 4'h8) || (cmd == 4'hA);
    arith = (cmd == 4'h4) || (cmd == 4'h2) || (cmd == 4'hA);
    e.cycles = fw + 2; e.irw = 1; e.rw = 0; e.mw = 0; e.pcw = 1;
    e.adr = 0; e.brimm = 0; e.rwsrc = 2'b00; e.timeout = 0;
    if (cond_holds(c, flags_m)) begin
      if (op == 2'b00 && impl) begin
        e.cycles = fw + 4;
        wr = !(cmd == 4'h8 || cmd == 4'hA);
        if (wr) begin
          e.rw = 1;
          if (rd == 4'hF) e.pcw = 2;
        end
        if (s) begin
          flags_m[3:2] = af[3:2];
          if (arith) flags_m[1:0] = af[1:0];
        end
      end else if (op == 2'b01) begin
        e.adr = 1 + mw;
        if (s) begin
          e.cycles = fw + 5 + mw; e.rw = 1; e.rwsrc = 2'b01;
          if (rd == 4'hF) e.pcw = 2;
        end else begin
          e.cycles = fw + 4 + mw; e.mw = 1 + mw;
        end
      end else if (op == 2'b10) begin
        e.cycles = fw + 3; e.pcw = 2; e.brimm = 1;
      end
    end
  endtask

  // Runs one instruction from its FETCH cycle to the next fetch, acting as the
  // memory (fw stalled fetch cycles, mw stalled data cycles) and tallying strobes.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                           input int fw, input int mw, output meas_t m);
    int cyc = 0;
    int mleft = mw;
    bit done = 0;
    m.cycles = 0; m.irw = 0; m.rw = 0; m.mw = 0; m.pcw = 0;
    m.adr = 0; m.brimm = 0; m.rwsrc = 2'b00; m.timeout = 0;
    instr = ins[31:12];
    alu_flags = af;
    while (!done) begin
      mem_ready = (cyc < fw) ? 1'b0 : 1'b1;
      #1;
      if (cyc >= fw && adr_src && mleft > 0) begin
        mem_ready = 1'b0;
        mleft--;
        #1;
      end
      if (ir_write && cyc > fw) begin
        done = 1;
      end else begin
        if (ir_write) m.irw++;
        if (reg_write) begin m.rw++; m.rwsrc = result_src; end
        if (mem_write) m.mw++;
        if (pc_write) m.pcw++;
        if (adr_src) m.adr++;
        if (pc_write && imm_src == 2'b10) m.brimm++;
        cyc++;
        if (cyc >= 40) begin
          m.timeout = 1;
          done = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    m.cycles = cyc;
    $display("instr %08h af=%b fw=%0d mw=%0d -> cycles=%0d rw=%0d mw=%0d pcw=%0d adr=%0d flags=%b",
             ins, af, fw, mw, m.cycles, m.rw, m.mw, m.pcw, m.adr, flags);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; instr = '0; alu_flags = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({pc_write, mem_write, ir_write, reg_write} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_strobes: got %b required 0000",
                 {pc_write, mem_write, ir_write, reg_write});
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src} !== 8'b11_0_1_10_10) begin
      n_err++;
      $display("FAIL first_fetch: got %b required 11011010",
               {ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src});
    end
    n_vec++;
    if (flags !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 0000", flags);
    end
`ifdef ARM_MC_PERF_EN
    n_vec++;
    if (ins_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_ins_cnt: got %0d required 0", ins_cnt);
    end
`endif
    flags_m = 4'b0000;
  endtask

  task automatic test_adds();
    meas_t m, e;
    model_step(32'hE2901005, 4'b0000, 0, 0, e);
    run_instr(32'hE2901005, 4'b0000, 0, 0, m);
    n_vec++;
    if (m.cycles !== 4) begin n_err++; $display("FAIL adds_cycles: got %0d required 4", m.cycles); end
    n_vec++;
    if (m.rw !== 1 || m.rwsrc !== 2'b00) begin
      n_err++; $display("FAIL adds_regwrite: got %0d pulses src %b required 1 src 00", m.rw, m.rwsrc);
    end
    n_vec++;
    if (flags !== 4'b0000) begin n_err++; $display("FAIL adds_flags: got %b required 0000", flags); end
  endtask

  task automatic test_ldr_wait();
    meas_t m, e;
    model_step(32'hE5902008, 4'b1010, 0, 2, e);
    run_instr(32'hE5902008, 4'b1010, 0, 2, m);
    n_vec++;
    if (m.cycles !== 7) begin n_err++; $display("FAIL ldr_cycles: got %0d required 7", m.cycles); end
    n_vec++;
    if (m.adr !== 3) begin n_err++; $display("FAIL ldr_adrsrc_hold: got %0d cycles required 3", m.adr); end
    n_vec++;
    if (m.rw !== 1 || m.rwsrc !== 2'b01) begin
      n_err++; $display("FAIL ldr_regwrite: got %0d pulses src %b required 1 src 01", m.rw, m.rwsrc);
    end
  endtask

  task automatic test_cmp_addne();
    meas_t m, e;
    model_step(32'hE1500000, 4'b0110, 0, 0, e);
    run_instr(32'hE1500000, 4'b0110, 0, 0, m);
    n_vec++;
    if (m.rw !== 0) begin n_err++; $display("FAIL cmp_regwrite: got %0d pulses required 0", m.rw); end
    n_vec++;
    if (flags !== 4'b0110) begin n_err++; $display("FAIL cmp_flags: got %b required 0110", flags); end
    model_step(32'h12833001, 4'b1111, 0, 0, e);
    run_instr(32'h12833001, 4'b1111, 0, 0, m);
    n_vec++;
    if (m.cycles !== 2) begin n_err++; $display("FAIL addne_cycles: got %0d required 2", m.cycles); end
    n_vec++;
    if (m.rw !== 0 || m.mw !== 0 || m.pcw !== 1) begin
      n_err++; $display("FAIL addne_writes: got rw=%0d mw=%0d pcw=%0d required 0 0 1", m.rw, m.mw, m.pcw);
    end
    n_vec++;
    if (flags !== 4'b0110) begin n_err++; $display("FAIL addne_flags: got %b required 0110", flags); end
  endtask

  task automatic test_branch();
    meas_t m, e;
    model_step(32'hEAFFFFFE, 4'b0000, 0, 0, e);
    run_instr(32'hEAFFFFFE, 4'b0000, 0, 0, m);
    n_vec++;
    if (m.cycles !== 3) begin n_err++; $display("FAIL b_cycles: got %0d required 3", m.cycles); end
    n_vec++;
    if (m.pcw !== 2 || m.brimm !== 1) begin
      n_err++; $display("FAIL b_pcwrite: got pcw=%0d imm10=%0d required 2 1", m.pcw, m.brimm);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] c, cmd, rd;
    logic [1:0] op;
    int r;
    c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    r = $urandom_range(0, 9);
    op = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    case ($urandom_range(0, 7))
      0: cmd = 4'h4;
      1: cmd = 4'h2;
      2: cmd = 4'h0;
      3: cmd = 4'hC;
      4: cmd = 4'h8;
      5: cmd = 4'hA;
      default: cmd = 4'($urandom_range(0, 15));
    endcase
    rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    return {c, op, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), rd, 12'($urandom_range(0, 4095))};
  endfunction

  task automatic test_random(input int n);
    meas_t m, e;
    logic [31:0] ins;
    logic [3:0] af;
    int fw, mw;
    for (int k = 0; k < n; k++) begin
      ins = rand_instr();
      af  = 4'($urandom_range(0, 15));
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      model_step(ins, af, fw, mw, e);
      run_instr(ins, af, fw, mw, m);
      n_vec++;
      if (m.timeout) begin n_err++; $display("FAIL rnd_timeout: instr %08h never returned to fetch", ins); end
      n_vec++;
      if (m.cycles !== e.cycles) begin
        n_err++; $display("FAIL rnd_cycles: instr %08h got %0d required %0d", ins, m.cycles, e.cycles);
      end
      n_vec++;
      if (m.irw !== e.irw) begin
        n_err++; $display("FAIL rnd_irwrite: instr %08h got %0d required %0d", ins, m.irw, e.irw);
      end
      n_vec++;
      if (m.rw !== e.rw || (e.rw > 0 && m.rwsrc !== e.rwsrc)) begin
        n_err++; $display("FAIL rnd_regwrite: instr %08h got %0d/%b required %0d/%b",
                          ins, m.rw, m.rwsrc, e.rw, e.rwsrc);
      end
      n_vec++;
      if (m.mw !== e.mw) begin
        n_err++; $display("FAIL rnd_memwrite: instr %08h got %0d required %0d", ins, m.mw, e.mw);
      end
      n_vec++;
      if (m.pcw !== e.pcw || m.brimm !== e.brimm) begin
        n_err++; $display("FAIL rnd_pcwrite: instr %08h got %0d/%0d required %0d/%0d",
                          ins, m.pcw, m.brimm, e.pcw, e.brimm);
      end
      n_vec++;
      if (m.adr !== e.adr) begin
        n_err++; $display("FAIL rnd_adrsrc: instr %08h got %0d required %0d", ins, m.adr, e.adr);
      end
      n_vec++;
      if (flags !== flags_m) begin
        n_err++; $display("FAIL rnd_flags: instr %08h got %b required %b", ins, flags, flags_m);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    meas_t m, e;
    // Load all four flags so the reset clear is observable.
    model_step(32'hE2901005, 4'b1111, 0, 0, e);
    run_instr(32'hE2901005, 4'b1111, 0, 0, m);
    instr = 20'hE5801;          // STR R1,[R0]
    mem_ready = 1'b1;
    #1;
    @(posedge clk); #1;         // DECODE
    @(posedge clk); #1;         // MEMADR
    mem_ready = 1'b0;
    @(posedge clk); #1;         // MEMWR, memory stalled
    n_vec++;
    if (mem_write !== 1'b1) begin n_err++; $display("FAIL memwr_active: got %b required 1", mem_write); end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_write, ir_write, pc_write, reg_write} !== 4'b0000) begin
      n_err++; $display("FAIL memwr_abort: got %b required 0000", {mem_write, ir_write, pc_write, reg_write});
    end
    n_vec++;
    if (flags !== 4'b0000) begin n_err++; $display("FAIL abort_flags: got %b required 0000", flags); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    flags_m = 4'b0000;
    @(posedge clk); #1;
    n_vec++;
    if (ir_write !== 1'b1 || adr_src !== 1'b0) begin
      n_err++; $display("FAIL restart_fetch: got irwrite=%b adrsrc=%b required 1 0", ir_write, adr_src);
    end
`ifdef ARM_MC_PERF_EN
    n_vec++;
    if (ins_cnt !== 32'd0) begin n_err++; $display("FAIL abort_ins_cnt: got %0d required 0", ins_cnt); end
`endif
    model_step(32'hE0811002, 4'b0101, 0, 0, e);
    run_instr(32'hE0811002, 4'b0101, 0, 0, m);
    n_vec++;
    if (m.cycles !== 4 || m.rw !== 1) begin
      n_err++; $display("FAIL restart_add: got cycles=%0d rw=%0d required 4 1", m.cycles, m.rw);
    end
  endtask

  initial begin
    flags_m = 4'b0000;
    test_reset();
    test_adds();
    test_ldr_wait();
    test_cmp_addne();
    test_branch();
    test_random(120);
    test_reset_mid_store();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
